// File: rtl/softmax_norm_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | softmax_norm_sequencer: buffers an exp vector, issues its sum to the |
// | reciprocal unit and streams exp_i * (1/sum) as Q1.15.      Rev 1.0   |
// +----------------------------------------------------------------------+
module softmax_norm_sequencer #(
   parameter int VEC_LEN       = 64,
   parameter int EXP_WIDTH     = 24,
   parameter int RECIP_WIDTH   = 24,
   parameter int OUT_WIDTH     = 16,
   parameter int RECIP_TIMEOUT = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [EXP_WIDTH-1:0]   exp_in,
   input  logic                   exp_valid,
   output logic                   exp_ready,
   output logic [EXP_WIDTH-1:0]   recip_x,
   output logic                   recip_start,
   input  logic [RECIP_WIDTH-1:0] recip_in,
   input  logic                   recip_done,
   output logic [OUT_WIDTH-1:0]   prob_out,
   output logic                   prob_valid,
   input  logic                   prob_ready,
   output logic                   prob_last,
   output logic                   busy,
   output logic                   err_timeout
);
   localparam logic [1:0] c_COLLECT = 2'd0;
   localparam logic [1:0] c_ISSUE   = 2'd1;
   localparam logic [1:0] c_WAIT    = 2'd2;
   localparam logic [1:0] c_EMIT    = 2'd3;

   localparam int CNT_W  = $clog2(VEC_LEN);
   localparam int TMR_W  = $clog2(RECIP_TIMEOUT + 1);
   localparam int PROD_W = EXP_WIDTH + RECIP_WIDTH;

   localparam logic [CNT_W-1:0]     c_LAST     = CNT_W'(VEC_LEN - 1);
   localparam logic [TMR_W-1:0]     c_TMR_LAST = TMR_W'(RECIP_TIMEOUT - 2);
   localparam logic [EXP_WIDTH-1:0] c_SUM_MAX  = {1'b0, {(EXP_WIDTH-1){1'b1}}};
   localparam logic [PROD_W-1:0]    c_ROUND    = PROD_W'(256);
   localparam logic [PROD_W-1:0]    c_ONE_Q    = PROD_W'(1) << (OUT_WIDTH - 1);

   logic [1:0]             state_q, state_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic [EXP_WIDTH-1:0]   sum_q, sum_d;
   logic [TMR_W-1:0]       timer_q, timer_d;
   logic [RECIP_WIDTH-1:0] recip_q, recip_d;
   logic [EXP_WIDTH-1:0]   recip_x_q, recip_x_d;
   logic                   err_q, err_d;
   logic [OUT_WIDTH-1:0]   prob_q, prob_d;
   logic                   pvalid_q, pvalid_d;
   logic                   plast_q, plast_d;
   logic                   buf_we;
   logic [EXP_WIDTH-1:0]   buf_q [VEC_LEN];

   logic [EXP_WIDTH-1:0]   w_exp_clamped;
   logic [EXP_WIDTH:0]     w_sum_ext;
   logic [EXP_WIDTH-1:0]   w_sum_sat;
   logic [PROD_W-1:0]      w_prod;
   logic [PROD_W-1:0]      w_q_round;
   logic [OUT_WIDTH-1:0]   w_q_sat;
   logic                   w_at_last;

   assign w_exp_clamped = exp_in[EXP_WIDTH-1] ? '0 : exp_in;
   assign w_sum_ext     = {1'b0, sum_q} + {1'b0, w_exp_clamped};
   assign w_sum_sat     = (w_sum_ext > {1'b0, c_SUM_MAX}) ? c_SUM_MAX : w_sum_ext[EXP_WIDTH-1:0];

   // recip = 2^24/sum_raw, so exp_raw*recip is p*2^24; dropping 9 bits leaves Q1.15.
   assign w_prod    = PROD_W'(buf_q[count_q]) * PROD_W'(recip_q);
   assign w_q_round = (w_prod + c_ROUND) >> 9;
   assign w_q_sat   = (w_q_round > c_ONE_Q) ? c_ONE_Q[OUT_WIDTH-1:0] : w_q_round[OUT_WIDTH-1:0];
   assign w_at_last = (count_q == c_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= c_COLLECT;
         count_q   <= '0;
         sum_q     <= '0;
         timer_q   <= '0;
         recip_q   <= '0;
         recip_x_q <= '0;
         err_q     <= 1'b0;
         prob_q    <= '0;
         pvalid_q  <= 1'b0;
         plast_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         sum_q     <= sum_d;
         timer_q   <= timer_d;
         recip_q   <= recip_d;
         recip_x_q <= recip_x_d;
         err_q     <= err_d;
         prob_q    <= prob_d;
         pvalid_q  <= pvalid_d;
         plast_q   <= plast_d;
      end
   end

   // Buffer contents are don't-care after reset, so it carries no reset.
   always_ff @(posedge clk) begin
      if (buf_we) buf_q[count_q] <= w_exp_clamped;
   end

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      sum_d     = sum_q;
      timer_d   = timer_q;
      recip_d   = recip_q;
      recip_x_d = recip_x_q;
      err_d     = err_q;
      prob_d    = prob_q;
      pvalid_d  = pvalid_q;
      plast_d   = plast_q;
      buf_we    = 1'b0;
      case (state_q)
         c_COLLECT: begin
            if (exp_valid) begin
               buf_we = 1'b1;
               sum_d  = w_sum_sat;
               if (w_at_last) begin
                  count_d   = '0;
                  recip_x_d = w_sum_sat;
                  state_d   = c_ISSUE;
               end else begin
                  count_d = count_q + 1'b1;
               end
            end
         end
         c_ISSUE: begin
            sum_d   = '0;
            timer_d = '0;
            if (sum_q == '0) begin
               recip_d = '0;
               state_d = c_EMIT;
            end else begin
               state_d = c_WAIT;
            end
         end
         c_WAIT: begin
            // A done arriving on the timeout cycle still wins.
            if (recip_done) begin
               recip_d = recip_in[RECIP_WIDTH-1] ? '0 : recip_in;
               state_d = c_EMIT;
            end else if (timer_q == c_TMR_LAST) begin
               err_d   = 1'b1;
               sum_d   = '0;
               state_d = c_COLLECT;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: begin
            if (!pvalid_q || prob_ready) begin
               if (pvalid_q && plast_q) begin
                  pvalid_d = 1'b0;
                  plast_d  = 1'b0;
                  state_d  = c_COLLECT;
               end else begin
                  prob_d   = w_q_sat;
                  pvalid_d = 1'b1;
                  plast_d  = w_at_last;
                  count_d  = w_at_last ? '0 : count_q + 1'b1;
               end
            end
         end
      endcase
   end

   always_comb begin
      exp_ready   = (state_q == c_COLLECT);
      busy        = (state_q != c_COLLECT);
      recip_start = (state_q == c_ISSUE) && (sum_q != '0);
      recip_x     = recip_x_q;
      prob_out    = prob_q;
      prob_valid  = pvalid_q;
      prob_last   = plast_q;
      err_timeout = err_q;
   end
endmodule
`default_nettype wire

// File: tb/tb_softmax_norm_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_softmax_norm_sequencer: table vectors, corner sequences and       |
// | random vectors against an arithmetic softmax model.        Rev 1.0   |
// +----------------------------------------------------------------------+
module tb_softmax_norm_sequencer;
   localparam int VL = 4;
   localparam int TO = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic [23:0] exp_in;
   logic        exp_valid;
   logic        exp_ready;
   logic [23:0] recip_x;
   logic        recip_start;
   logic [23:0] recip_in;
   logic        recip_done;
   logic [15:0] prob_out;
   logic        prob_valid;
   logic        prob_ready;
   logic        prob_last;
   logic        busy;
   logic        err_timeout;

   softmax_norm_sequencer #(
      .VEC_LEN(VL), .EXP_WIDTH(24), .RECIP_WIDTH(24), .OUT_WIDTH(16), .RECIP_TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .exp_in(exp_in), .exp_valid(exp_valid), .exp_ready(exp_ready),
      .recip_x(recip_x), .recip_start(recip_start),
      .recip_in(recip_in), .recip_done(recip_done),
      .prob_out(prob_out), .prob_valid(prob_valid), .prob_ready(prob_ready),
      .prob_last(prob_last), .busy(busy), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [VL-1:0][23:0] e;
      logic [23:0]         r;
      int                  dly;
      int                  se;
      int                  sn;
      logic [23:0]         x;
      bit                  st;
      logic [VL-1:0][15:0] p;
   } vec_t;

   vec_t tbl [9];
   int   total = 0;
   int   bad = 0;
   int   n_start = 0;

   always @(negedge clk) if (recip_start === 1'b1) n_start++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
      end
   endtask

   task automatic expired(input string name);
      total++;
      bad++;
      $display("FAIL %s: wait bound expired at %0t", name, $time);
   endtask

   function automatic logic [15:0] mprob(input logic [23:0] e, input logic [23:0] r);
      longint ev, rv, q;
      ev = e[23] ? 64'd0 : longint'(e);
      rv = r[23] ? 64'd0 : longint'(r);
      q  = (ev * rv + 256) / 512;
      return (q > 32768) ? 16'h8000 : 16'(q);
   endfunction

   function automatic logic [23:0] msum(input logic [VL-1:0][23:0] e);
      longint s = 0;
      for (int i = 0; i < VL; i++) s += e[i][23] ? 64'd0 : longint'(e[i]);
      return (s > 64'h7FFFFF) ? 24'h7FFFFF : 24'(s);
   endfunction

   function automatic void set_vec(input int i, input logic [23:0] e0, e1, e2, e3, r,
                                   input int dly, se, sn, input logic [23:0] x, input bit st,
                                   input logic [15:0] p0, p1, p2, p3);
      tbl[i].e[0] = e0; tbl[i].e[1] = e1; tbl[i].e[2] = e2; tbl[i].e[3] = e3;
      tbl[i].r = r; tbl[i].dly = dly; tbl[i].se = se; tbl[i].sn = sn;
      tbl[i].x = x; tbl[i].st = st;
      tbl[i].p[0] = p0; tbl[i].p[1] = p1; tbl[i].p[2] = p2; tbl[i].p[3] = p3;
   endfunction

   // Presents the vector; returns at the negedge of the ISSUE cycle.
   task automatic feed(input logic [VL-1:0][23:0] e);
      for (int i = 0; i < VL; i++) begin
         int w = 0;
         exp_in = e[i];
         exp_valid = 1'b1;
         while (exp_ready !== 1'b1 && w < 100) begin @(negedge clk); w++; end
         if (w >= 100) expired("exp_ready_wait");
         @(negedge clk);
      end
      exp_valid = 1'b0;
      exp_in = 24'($urandom);
   endtask

   task automatic reply(input int dly, input logic [23:0] r, input bit st);
      if (st) begin
         for (int k = 0; k < dly; k++) @(negedge clk);
         recip_in = r;
         recip_done = 1'b1;
         @(negedge clk);
         recip_done = 1'b0;
         recip_in = 24'($urandom);
      end else begin
         @(negedge clk);
      end
      chk("pv_on_emit_entry", 32'(prob_valid), 32'd0);
      @(negedge clk);
      chk("first_pv_latency", 32'(prob_valid), 32'd1);
   endtask

   task automatic collect(input logic [VL-1:0][15:0] p, input int se, input int sn,
                          input int abort_at, output bit aborted);
      int got = 0, hold = 0, budget = 0;
      logic [15:0] sv_out = '0;
      logic        sv_last = 1'b0;
      aborted = 1'b0;
      while (got < VL && budget < 300) begin
         if (got == abort_at && prob_valid === 1'b1) begin
            #2 rst = 1'b1;
            #1;
            chk("rst_prob_valid", 32'(prob_valid), 32'd0);
            chk("rst_prob_out", 32'(prob_out), 32'd0);
            chk("rst_prob_last", 32'(prob_last), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_recip_x", 32'(recip_x), 32'd0);
            chk("rst_err_cleared", 32'(err_timeout), 32'd0);
            prob_ready = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            aborted = 1'b1;
            return;
         end
         if (prob_valid === 1'b1) begin
            if (got == se && hold < sn) begin
               if (hold > 0) begin
                  chk("stall_out_stable", 32'(prob_out), 32'(sv_out));
                  chk("stall_last_stable", 32'(prob_last), 32'(sv_last));
               end
               sv_out = prob_out;
               sv_last = prob_last;
               prob_ready = 1'b0;
               hold++;
            end else begin
               if (got == se && hold > 0) chk("stall_out_stable", 32'(prob_out), 32'(sv_out));
               chk("prob_out", 32'(prob_out), 32'(p[got]));
               chk("prob_last", 32'(prob_last), 32'(got == VL - 1));
               prob_ready = 1'b1;
               got++;
            end
         end else begin
            prob_ready = 1'b0;
         end
         @(negedge clk);
         budget++;
      end
      prob_ready = 1'b0;
      if (got < VL) expired("collect");
      chk("throughput_cycles", 32'(budget), 32'(VL + ((se >= 0 && se < VL) ? sn : 0)));
      chk("pv_after_last", 32'(prob_valid), 32'd0);
      chk("busy_after_last", 32'(busy), 32'd0);
      chk("exp_ready_after_last", 32'(exp_ready), 32'd1);
   endtask

   task automatic run_vec(input logic [VL-1:0][23:0] e, input logic [23:0] r, input int dly,
                          input int se, input int sn, input int abort_at,
                          input logic [23:0] x, input bit st, input logic [VL-1:0][15:0] p);
      int s0;
      bit ab;
      s0 = n_start;
      feed(e);
      chk("recip_start", 32'(recip_start), 32'(st));
      if (st) chk("recip_x", 32'(recip_x), 32'(x));
      chk("busy_issue", 32'(busy), 32'd1);
      chk("exp_ready_issue", 32'(exp_ready), 32'd0);
      reply(dly, r, st);
      collect(p, se, sn, abort_at, ab);
      if (!ab) chk("start_pulses", 32'(n_start - s0), 32'(st));
   endtask

   logic [VL-1:0][23:0] rv_e;
   logic [VL-1:0][15:0] rv_p;
   logic [23:0]         rv_r, rv_x;
   bit                  rv_st;
   int                  w;
   int                  s0;

   initial begin
      rst = 1'b1; exp_in = '0; exp_valid = 1'b0; recip_in = '0; recip_done = 1'b0; prob_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_prob_valid", 32'(prob_valid), 32'd0);
      chk("reset_prob_out", 32'(prob_out), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_err", 32'(err_timeout), 32'd0);
      chk("reset_recip_start", 32'(recip_start), 32'd0);
      chk("reset_recip_x", 32'(recip_x), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("exp_ready_after_reset", 32'(exp_ready), 32'd1);

      set_vec(0, 24'h400, 24'h400, 24'h400, 24'h400, 24'h1000, 20, -1, 0, 24'h1000, 1,
              16'h2000, 16'h2000, 16'h2000, 16'h2000);
      set_vec(1, 24'h80, 24'h80, 24'h80, 24'h80, 24'h8000, 5, -1, 0, 24'h200, 1,
              16'h2000, 16'h2000, 16'h2000, 16'h2000);
      set_vec(2, 24'hC00, 24'h400, 24'h0, 24'h0, 24'h1000, 3, 1, 3, 24'h1000, 1,
              16'h6000, 16'h2000, 16'h0, 16'h0);
      set_vec(3, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h1000, 2, -1, 0, 24'h7FFFFF, 1,
              16'h8000, 16'h8000, 16'h8000, 16'h8000);
      set_vec(4, 24'hFFFC00, 24'hFFFC00, 24'hFFFC00, 24'hFFFC00, 24'h1000, 1, -1, 0, 24'h0, 0,
              16'h0, 16'h0, 16'h0, 16'h0);
      set_vec(5, 24'hFFFC00, 24'h400, 24'h0, 24'h0, 24'h1000, 1, -1, 0, 24'h400, 1,
              16'h0, 16'h2000, 16'h0, 16'h0);
      set_vec(6, 24'h400, 24'h400, 24'h400, 24'h400, 24'h800000, 7, -1, 0, 24'h1000, 1,
              16'h0, 16'h0, 16'h0, 16'h0);
      set_vec(7, 24'h1, 24'h2, 24'h3, 24'h100, 24'hFF, 4, 3, 1, 24'h106, 1,
              16'h0, 16'h1, 16'h1, 16'h80);
      set_vec(8, 24'h400, 24'h400, 24'h400, 24'h400, 24'h1000, TO - 1, -1, 0, 24'h1000, 1,
              16'h2000, 16'h2000, 16'h2000, 16'h2000);

      for (int i = 0; i < 9; i++)
         run_vec(tbl[i].e, tbl[i].r, tbl[i].dly, tbl[i].se, tbl[i].sn, -1,
                 tbl[i].x, tbl[i].st, tbl[i].p);
      chk("err_after_late_done", 32'(err_timeout), 32'd0);

      // Stray done while idle must not start anything.
      recip_in = 24'h1000; recip_done = 1'b1;
      @(negedge clk);
      recip_done = 1'b0;
      @(negedge clk);
      chk("stray_done_busy", 32'(busy), 32'd0);
      chk("stray_done_pv", 32'(prob_valid), 32'd0);

      // Reciprocal unit never answers.
      rv_e = {VL{24'h400}};
      s0 = n_start;
      feed(rv_e);
      chk("timeout_start", 32'(recip_start), 32'd1);
      w = 0;
      while (err_timeout !== 1'b1 && w < 200) begin @(negedge clk); w++; end
      if (w >= 200) expired("timeout_wait");
      chk("timeout_cycles", 32'(w), 32'(TO));
      chk("timeout_busy", 32'(busy), 32'd0);
      chk("timeout_pv", 32'(prob_valid), 32'd0);
      chk("timeout_exp_ready", 32'(exp_ready), 32'd1);
      run_vec(tbl[0].e, tbl[0].r, 10, -1, 0, -1, tbl[0].x, tbl[0].st, tbl[0].p);
      chk("err_sticky", 32'(err_timeout), 32'd1);

      // Reset while element 2 is on the output, then a clean vector.
      run_vec(tbl[2].e, tbl[2].r, 6, -1, 0, 2, tbl[2].x, tbl[2].st, tbl[2].p);
      run_vec(tbl[0].e, tbl[0].r, 8, -1, 0, -1, tbl[0].x, tbl[0].st, tbl[0].p);

      for (int n = 0; n < 30; n++) begin
         for (int i = 0; i < VL; i++) begin
            case ($urandom_range(0, 5))
               0:       rv_e[i] = 24'($urandom);
               1:       rv_e[i] = 24'h0;
               2:       rv_e[i] = 24'h7FFFFF - 24'($urandom_range(0, 255));
               default: rv_e[i] = 24'($urandom_range(0, 24'h3FFF));
            endcase
         end
         rv_r  = ($urandom_range(0, 7) == 0) ? 24'($urandom) : 24'($urandom_range(0, 24'h20000));
         rv_x  = msum(rv_e);
         rv_st = (rv_x != 24'h0);
         for (int i = 0; i < VL; i++) rv_p[i] = rv_st ? mprob(rv_e[i], rv_r) : 16'h0;
         run_vec(rv_e, rv_r, $urandom_range(1, 40), $urandom_range(0, VL - 1),
                 $urandom_range(0, 3), -1, rv_x, rv_st, rv_p);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
